// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges a two-slot writeback stream and a load-return
// stream onto the two register-file write ports. Loads wait in a small FIFO
// and take whichever ports writeback leaves free. When the FIFO gets too full,
// a DRAIN state blocks writeback so that two loads can retire per cycle.
// Optional feature macro: REGFILE_ARB_BYPASS_EN. When it is defined, a load
// that arrives while the FIFO is empty goes straight to a free port.
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int HIWAT = 3,
    parameter int LOWAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [1:0]  wb_write,
    input  logic [31:0] wb_d1,
    input  logic [31:0] wb_d2,
    input  logic [4:0]  wb_a1,
    input  logic [4:0]  wb_a2,
    output logic        wb_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic [4:0]  ld_addr,
    output logic        ld_ready,
    output logic [31:0] wr1,
    output logic [31:0] wr2,
    output logic [4:0]  wa1,
    output logic [4:0]  wa2,
    output logic [1:0]  write,
    output logic [2:0]  fifo_count,
    output logic        drain
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t        state, state_next;
    logic [31:0]   mem_data [DEPTH];
    logic [4:0]    mem_addr [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_next, second_ptr;

    logic          wb_acc, ld_acc, push, pop1, pop2;
    logic [1:0]    wb_use, pop_n, nxt_write;
    logic [31:0]   nxt_wr1, nxt_wr2;
    logic [4:0]    nxt_wa1, nxt_wa2;
    logic [2:0]    count_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign wb_ready = !rst && (state == NORMAL);
    assign ld_ready = !rst && (fifo_count < 3'(DEPTH));

    // Work out this cycle's port usage. Writeback takes its slots first, FIFO
    // entries fill the remaining ports oldest-first, and then the load either
    // bypasses the FIFO or is pushed onto its tail.
    always_comb begin
        wb_acc     = wb_valid && wb_ready;
        ld_acc     = ld_valid && ld_ready;
        wb_use     = wb_acc ? wb_write : 2'b00;
        nxt_write  = wb_use;
        nxt_wr1    = wb_d1;
        nxt_wa1    = wb_a1;
        nxt_wr2    = wb_d2;
        nxt_wa2    = wb_a2;
        pop1       = 1'b0;
        pop2       = 1'b0;
        push       = 1'b0;
        second_ptr = ptr_inc(rd_ptr);

        if (!wb_use[0] && fifo_count != 3'd0) begin
            pop1         = 1'b1;
            nxt_wr1      = mem_data[rd_ptr];
            nxt_wa1      = mem_addr[rd_ptr];
            nxt_write[0] = 1'b1;
        end
        if (!wb_use[1]) begin
            if (pop1 && fifo_count >= 3'd2) begin
                pop2         = 1'b1;
                nxt_wr2      = mem_data[second_ptr];
                nxt_wa2      = mem_addr[second_ptr];
                nxt_write[1] = 1'b1;
            end else if (!pop1 && fifo_count != 3'd0) begin
                pop2         = 1'b1;
                nxt_wr2      = mem_data[rd_ptr];
                nxt_wa2      = mem_addr[rd_ptr];
                nxt_write[1] = 1'b1;
            end
        end

`ifdef REGFILE_ARB_BYPASS_EN
        if (ld_acc) begin
            if (state == NORMAL && fifo_count == 3'd0 && !wb_use[0]) begin
                nxt_wr1      = ld_data;
                nxt_wa1      = ld_addr;
                nxt_write[0] = 1'b1;
            end else if (state == NORMAL && fifo_count == 3'd0 && !wb_use[1]) begin
                nxt_wr2      = ld_data;
                nxt_wa2      = ld_addr;
                nxt_write[1] = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
`else
        push = ld_acc;
`endif

        if (nxt_write == 2'b11 && nxt_wa1 == nxt_wa2)
            nxt_write[0] = 1'b0;

        pop_n = {1'b0, pop1} + {1'b0, pop2};
        if (pop_n == 2'd2)
            rd_ptr_next = ptr_inc(second_ptr);
        else if (pop_n == 2'd1)
            rd_ptr_next = second_ptr;
        else
            rd_ptr_next = rd_ptr;

        count_next = fifo_count + {2'b00, push} - {1'b0, pop_n};

        state_next = state;
        if (state == NORMAL && count_next >= 3'(HIWAT))
            state_next = DRAIN;
        else if (state == DRAIN && count_next <= 3'(LOWAT))
            state_next = NORMAL;
    end

    // FIFO storage needs no reset because occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_data[wr_ptr] <= ld_data;
            mem_addr[wr_ptr] <= ld_addr;
        end
    end

    // Registered port outputs, FIFO pointers and the NORMAL/DRAIN state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr1        <= '0;
            wr2        <= '0;
            wa1        <= '0;
            wa2        <= '0;
            write      <= 2'b00;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            state      <= NORMAL;
            drain      <= 1'b0;
        end else begin
            write <= nxt_write;
            if (nxt_write[0]) begin
                wr1 <= nxt_wr1;
                wa1 <= nxt_wa1;
            end
            if (nxt_write[1]) begin
                wr2 <= nxt_wr2;
                wa2 <= nxt_wa2;
            end
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr     <= rd_ptr_next;
            fifo_count <= count_next;
            state      <= state_next;
            drain      <= (state_next == DRAIN);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter. A queue-based reference model
// predicts each cycle's port writes. The predictions go onto a scoreboard
// queue and are compared once the DUT registers its outputs.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;
    localparam int HIWAT = 3;
    localparam int LOWAT = 1;

    logic        clk, rst;
    logic        wb_valid, ld_valid;
    logic [1:0]  wb_write;
    logic [31:0] wb_d1, wb_d2, ld_data;
    logic [4:0]  wb_a1, wb_a2, ld_addr;
    logic        wb_ready, ld_ready, drain;
    logic [31:0] wr1, wr2;
    logic [4:0]  wa1, wa2;
    logic [1:0]  write;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
    } entry_t;

    typedef struct {
        logic [1:0]  write;
        logic [31:0] wr1, wr2;
        logic [4:0]  wa1, wa2;
        logic [2:0]  count;
        logic        drain;
    } exp_t;

    entry_t      m_q[$];
    exp_t        exp_q[$];
    logic        m_drain;
    logic [31:0] m_wr1, m_wr2;
    logic [4:0]  m_wa1, m_wa2;
    int          checks = 0;
    int          errors = 0;

    regfile_write_arbiter #(.DEPTH(DEPTH), .HIWAT(HIWAT), .LOWAT(LOWAT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_write(wb_write),
        .wb_d1(wb_d1), .wb_d2(wb_d2), .wb_a1(wb_a1), .wb_a2(wb_a2),
        .wb_ready(wb_ready),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_addr(ld_addr),
        .ld_ready(ld_ready),
        .wr1(wr1), .wr2(wr2), .wa1(wa1), .wa2(wa2),
        .write(write), .fifo_count(fifo_count), .drain(drain)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic compareOutputs(input exp_t e);
        checkOutput("write", {30'd0, write}, {30'd0, e.write});
        checkOutput("wr1", wr1, e.wr1);
        checkOutput("wa1", {27'd0, wa1}, {27'd0, e.wa1});
        checkOutput("wr2", wr2, e.wr2);
        checkOutput("wa2", {27'd0, wa2}, {27'd0, e.wa2});
        checkOutput("fifo_count", {29'd0, fifo_count}, {29'd0, e.count});
        checkOutput("drain", {31'd0, drain}, {31'd0, e.drain});
    endtask

    // Called at a negedge: holds rst for one edge and checks the cleared state.
    task automatic applyReset();
        exp_t e;
        rst = 1'b1;
        #1;
        checkOutput("wb_ready_rst", {31'd0, wb_ready}, 32'd0);
        checkOutput("ld_ready_rst", {31'd0, ld_ready}, 32'd0);
        m_q.delete();
        m_drain = 1'b0;
        m_wr1 = '0; m_wr2 = '0; m_wa1 = '0; m_wa2 = '0;
        e = '{write: 2'b00, wr1: 32'd0, wr2: 32'd0, wa1: 5'd0, wa2: 5'd0, count: 3'd0, drain: 1'b0};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compareOutputs(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge: drives one cycle of inputs, predicts the result,
    // queues it and compares it after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [1:0] w,
                                 input logic [31:0] d1, input logic [4:0] a1,
                                 input logic [31:0] d2, input logic [4:0] a2,
                                 input logic lv, input logic [31:0] ldd,
                                 input logic [4:0] lda);
        exp_t   e;
        entry_t ent;
        logic   wb_acc, ld_acc, bypassed;
        logic [1:0] use_w;
        int     old_size;
        wb_valid = v; wb_write = w; wb_d1 = d1; wb_a1 = a1; wb_d2 = d2; wb_a2 = a2;
        ld_valid = lv; ld_data = ldd; ld_addr = lda;
        #1;
        checkOutput("wb_ready", {31'd0, wb_ready}, {31'd0, !m_drain});
        checkOutput("ld_ready", {31'd0, ld_ready}, (m_q.size() < DEPTH) ? 32'd1 : 32'd0);

        wb_acc   = v && !m_drain;
        ld_acc   = lv && (m_q.size() < DEPTH);
        use_w    = wb_acc ? w : 2'b00;
        old_size = m_q.size();
        e.write = use_w;
        e.wr1 = d1; e.wa1 = a1; e.wr2 = d2; e.wa2 = a2;
        if (!use_w[0] && m_q.size() > 0) begin
            ent = m_q.pop_front();
            e.wr1 = ent.data; e.wa1 = ent.addr; e.write[0] = 1'b1;
        end
        if (!use_w[1] && m_q.size() > 0) begin
            ent = m_q.pop_front();
            e.wr2 = ent.data; e.wa2 = ent.addr; e.write[1] = 1'b1;
        end
        bypassed = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
        if (ld_acc && !m_drain && old_size == 0) begin
            if (!use_w[0]) begin
                e.wr1 = ldd; e.wa1 = lda; e.write[0] = 1'b1; bypassed = 1'b1;
            end else if (!use_w[1]) begin
                e.wr2 = ldd; e.wa2 = lda; e.write[1] = 1'b1; bypassed = 1'b1;
            end
        end
`endif
        if (ld_acc && !bypassed)
            m_q.push_back('{data: ldd, addr: lda});
        if (e.write == 2'b11 && e.wa1 == e.wa2)
            e.write[0] = 1'b0;
        if (e.write[0]) begin m_wr1 = e.wr1; m_wa1 = e.wa1; end
        else begin e.wr1 = m_wr1; e.wa1 = m_wa1; end
        if (e.write[1]) begin m_wr2 = e.wr2; m_wa2 = e.wa2; end
        else begin e.wr2 = m_wr2; e.wa2 = m_wa2; end
        e.count = 3'(m_q.size());
        if (!m_drain && m_q.size() >= HIWAT)
            m_drain = 1'b1;
        else if (m_drain && m_q.size() <= LOWAT)
            m_drain = 1'b0;
        e.drain = m_drain;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        compareOutputs(exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 2'b00, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0);
    endtask

    // Directed scenarios followed by a randomized fill/drain run.
    initial begin
        rst = 1'b1;
        wb_valid = 1'b0; wb_write = 2'b00; wb_d1 = '0; wb_d2 = '0; wb_a1 = '0; wb_a2 = '0;
        ld_valid = 1'b0; ld_data = '0; ld_addr = '0;
        @(negedge clk);
        applyReset();

        // Dual-slot writeback.
        applyStimulus(1'b1, 2'b11, 32'hAAAA0001, 5'd3, 32'hBBBB0002, 5'd4, 1'b0, 32'd0, 5'd0);
        checkOutput("dual_wb_write", {30'd0, write}, 32'd3);
        idle(1);
        checkOutput("idle_write", {30'd0, write}, 32'd0);
        checkOutput("idle_hold_wa2", {27'd0, wa2}, 32'd4);

        // Slot1 writeback plus a load that lands on port2.
        applyStimulus(1'b1, 2'b01, 32'h55550005, 5'd5, 32'd0, 5'd0, 1'b1, 32'h1234, 5'd9);
        idle(2);

        // Loads back-to-back while writeback holds both ports; reset inside DRAIN.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 2'b11, 32'h10 + i, 5'd10, 32'h20 + i, 5'd11,
                          1'b1, 32'hD000_0000 + i, 5'(16 + i));
        checkOutput("drain_at_3", {31'd0, drain}, 32'd1);
        checkOutput("count_at_3", {29'd0, fifo_count}, 32'd3);
        applyReset();
        idle(3);

        // Same sequence again, this time allowed to drain down.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 2'b11, 32'h30 + i, 5'd12, 32'h40 + i, 5'd13,
                          (i < 4), 32'hE000_0000 + i, 5'(20 + i));
        idle(3);

        // Address collision between a popped load and writeback slot2.
        applyStimulus(1'b1, 2'b11, 32'h1, 5'd1, 32'h2, 5'd2, 1'b1, 32'h7777, 5'd7);
        applyStimulus(1'b1, 2'b10, 32'h0, 5'd0, 32'hCAFE0007, 5'd7, 1'b0, 32'd0, 5'd0);
        checkOutput("collide_write", {30'd0, write}, 32'd2);
        checkOutput("collide_wr2", wr2, 32'hCAFE0007);
        idle(2);

        // Randomized traffic well past several pointer wraps.
        for (int i = 0; i < 60; i++)
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          $urandom, 5'($urandom_range(0, 31)),
                          $urandom, 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) != 0), 32'hF000_0000 + i,
                          5'($urandom_range(0, 31)));
        idle(4);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameters: DEPTH, 4, load FIFO entries; HIWAT, 3, count entering DRAIN; LOWAT, 1, count leaving DRAIN.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_valid  in  1  writeback request present
- wb_write  in  2  per-slot write enables (bit0 slot1, bit1 slot2)
- wb_d1, wb_d2  in  32  slot data
- wb_a1, wb_a2  in  5  slot register addresses
- wb_ready  out  1  writeback request accepted this cycle
- ld_valid  in  1  load-return write request
- ld_data  in  32  load data
- ld_addr  in  5  load destination register
- ld_ready  out  1  load accepted this cycle
- wr1, wr2  out  32  register-file write data, ports 1/2
- wa1, wa2  out  5  register-file write addresses
- write  out  2  register-file port enables (bit0 port1, bit1 port2)
- fifo_count  out  3  load FIFO occupancy
- drain  out  1  high in DRAIN state

Function
REQ-003 SHALL accept WB when wb_valid && wb_ready, and a load when ld_valid && ld_ready.
REQ-004 SHALL drive wb_ready = !rst && state==NORMAL; ld_ready = !rst && fifo_count<DEPTH; a same-cycle pop SHALL NOT grant a full FIFO extra credit.
REQ-005 SHALL register all port outputs; accepted WB slots appear on ports the cycle after acceptance (latency 1).
REQ-006 SHALL map accepted WB slot1 to port1, slot2 to port2; write bits clear for unused slots.
REQ-007 NORMAL: each port not used by WB SHALL take the FIFO head in order, port1 first; at most one pop per free port.
REQ-008 DRAIN: WB blocked; SHALL pop up to two FIFO entries per cycle, oldest to port1.
REQ-009 Accepted loads SHALL push to the FIFO tail (unless bypassed per REQ-016); push and pop in the same cycle SHALL both take effect.
REQ-010 FSM NORMAL->DRAIN at an edge where next fifo_count>=HIWAT; DRAIN->NORMAL where next fifo_count<=LOWAT; no other states.
REQ-011 If both ports target the same address in one cycle, port2 SHALL be written and port1's write bit cleared; any popped entry still leaves the FIFO.
REQ-012 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH nor underflow.
REQ-013 Cycles with no work SHALL drive write=2'b00; wr*/wa* hold their last values.

Reset
REQ-014 While rst is high at an edge: wr1=wr2=0, wa1=wa2=0, write=2'b00, FIFO emptied (fifo_count=0), state NORMAL, drain=0; wb_ready=ld_ready=0 during rst.
REQ-015 Reset mid-operation SHALL discard all buffered loads and in-flight WB data without producing a write.

Configuration
REQ-016 Macro REGFILE_ARB_BYPASS_EN: defined -> an accepted load with FIFO empty and a port free after WB (NORMAL only) SHALL go straight to that port next cycle (latency 1), no push; undefined -> every load is pushed and written no earlier than 2 cycles after acceptance.

Verification
REQ-017 Bench SHALL cover:
- WB wb_write=11, a1=3/d1=0xAAAA0001, a2=4/d2=0xBBBB0002 -> next cycle write=11, wa1=3, wa2=4, data match.
- WB write=01 (a1=5) plus load addr 9 data 0x1234, FIFO empty -> port2 writes r9 next cycle (BYPASS) or 2 cycles after acceptance (no BYPASS).
- 4 back-to-back loads, WB both slots every cycle -> fifo_count 1,2,3; drain=1, wb_ready=0; two pops per cycle until count<=1; ld_ready=0 at count 4.
- Head entry addr 7 pops to port1 while WB slot2 writes addr 7 -> write=10, wa2=7, WB data wins, fifo_count decrements.
- rst asserted with fifo_count=3 in DRAIN -> next cycle all outputs 0, count 0, NORMAL; no stale writes after release.
- Fill/drain over 10+ entries -> loads written in arrival order, no loss or duplication across pointer wrap.
